// File: rtl/io_bridge.sv
// CPU-to-RAM bridge with a memory-mapped UART transmitter (TXDATA at 0xFF00, STATUS at 0xFF01).
// Define IO_BRIDGE_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module io_bridge #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_address,
    input  logic [31:0] cpu_data,
    input  logic        cpu_wren,
    output logic [31:0] cpu_q,
    output logic [15:0] ram_address,
    output logic [31:0] ram_data,
    output logic        ram_wren,
    input  logic [31:0] ram_q,
    output logic        tx
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] LevelFull = LW'(FIFO_DEPTH);
    localparam logic [15:0] BitEnd = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} tx_state_e;

    logic          is_ram, is_txdata, is_status;
    logic          sel_ram_q;
    logic [31:0]   io_rdata_q, status_img;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          fifo_full, fifo_empty, push_req, push, pop;
    logic          ovf_q, ovf_d;
    tx_state_e     state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d, bit_end, tx_busy;
`ifdef IO_BRIDGE_PARITY_EN
    logic          par_q, par_d;
`endif

    assign is_ram    = cpu_address < 16'hFF00;
    assign is_txdata = cpu_address == 16'hFF00;
    assign is_status = cpu_address == 16'hFF01;

    assign ram_address = cpu_address;
    assign ram_data    = cpu_data;
    assign ram_wren    = cpu_wren & is_ram;

    assign fifo_full  = level_q == LevelFull;
    assign fifo_empty = level_q == '0;
    assign tx_busy    = state_q != StIdle;
    assign bit_end    = cnt_q == BitEnd;
    assign tx         = tx_q;

    assign status_img = {20'd0, ovf_q, tx_busy, fifo_empty, fifo_full, 8'(level_q)};
    assign cpu_q      = sel_ram_q ? ram_q : io_rdata_q;

    // A full FIFO still accepts a push when the serializer drains a byte on the same edge.
    always_comb begin
        push_req = cpu_wren & is_txdata;
        push     = push_req & (~fifo_full | pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        ovf_d    = ovf_q;
        if (cpu_wren && is_status) ovf_d = 1'b0;
        if (push_req && !push)     ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= cpu_data[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_ram_q  <= 1'b1;
            io_rdata_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            sel_ram_q  <= is_ram;
            io_rdata_q <= is_status ? status_img : 32'd0;
            level_q    <= level_d;
            ovf_q      <= ovf_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // tx_d is the line level for the coming bit period, so tx stays a pure register output.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        tx_d      = tx_q;
        pop       = 1'b0;
`ifdef IO_BRIDGE_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StStart;
                    cnt_d   = '0;
                    shreg_d = fifo_mem[rd_ptr_q];
                    tx_d    = 1'b0;
`ifdef IO_BRIDGE_PARITY_EN
                    par_d   = ^fifo_mem[rd_ptr_q];
`endif
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = shreg_q[0];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef IO_BRIDGE_PARITY_EN
                        state_d = StParity;
                        tx_d    = par_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef IO_BRIDGE_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            StStop: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
`ifdef IO_BRIDGE_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
`ifdef IO_BRIDGE_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: address-decode vector table, UART byte scoreboard
// fed by a line monitor, and hand-written FIFO overflow / same-edge push-pop / reset sequences.
module tb_io_bridge;

    localparam int unsigned Cpb   = 4;
    localparam int unsigned Depth = 8;
`ifdef IO_BRIDGE_PARITY_EN
    localparam int NBits = 11;
    localparam bit ParEn = 1'b1;
`else
    localparam int NBits = 10;
    localparam bit ParEn = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] cpu_address;
    logic [31:0] cpu_data;
    logic        cpu_wren;
    logic [31:0] cpu_q;
    logic [15:0] ram_address;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic [31:0] ram_q;
    logic        tx;

    io_bridge #(
        .CLKS_PER_BIT(Cpb),
        .FIFO_DEPTH  (Depth)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_address(cpu_address),
        .cpu_data   (cpu_data),
        .cpu_wren   (cpu_wren),
        .cpu_q      (cpu_q),
        .ram_address(ram_address),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .ram_q      (ram_q),
        .tx         (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model with one-clock read latency.
    logic [31:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_address[7:0]] <= ram_data;
        ram_q <= ram_mem[ram_address[7:0]];
    end

    typedef struct {
        logic [7:0] data;
        logic       framing_ok;
    } rx_t;

    rx_t        rx_q[$];
    logic [7:0] exp_q[$];
    int         frame_starts = 0;

    // UART line monitor: samples the middle of every bit period.
    initial begin : monitor
        logic [10:0] smp;
        bit          ab;
        rx_t         r;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                frame_starts++;
                smp = '1;
                ab  = 1'b0;
                for (int c = 1; c <= 2 + (NBits - 1) * Cpb; c++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) ab = 1'b1;
                    if (c >= 2 && (c - 2) % Cpb == 0) smp[(c - 2) / Cpb] = tx;
                end
                if (!ab) begin
                    r.data       = smp[8:1];
                    r.framing_ok = (smp[0] == 1'b0) && (smp[NBits-1] == 1'b1);
                    if (ParEn && smp[9] != ^smp[8:1]) r.framing_ok = 1'b0;
                    rx_q.push_back(r);
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(logic [15:0] a, logic [31:0] d);
        cpu_address = a;
        cpu_data    = d;
        cpu_wren    = 1'b1;
        @(negedge clk);
        cpu_wren = 1'b0;
    endtask

    task automatic push_byte(logic [7:0] b);
        exp_q.push_back(b);
        wr(16'hFF00, {24'hABCDEF, b});
    endtask

    task automatic rd_check(string name, logic [15:0] a, logic [31:0] e);
        cpu_address = a;
        cpu_wren    = 1'b0;
        @(negedge clk);
        check(name, 64'(cpu_q), 64'(e));
    endtask

    task automatic drain(int bound);
        rx_t        r;
        logic [7:0] e;
        for (int i = 0; i < bound && (exp_q.size() > 0 || rx_q.size() > 0); i++) begin
            @(negedge clk);
            #1;
            while (rx_q.size() > 0) begin
                r = rx_q.pop_front();
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL uart_extra: got byte %0h expected none", r.data);
                end else begin
                    e = exp_q.pop_front();
                    check("uart_byte", 64'(r.data), 64'(e));
                    check("uart_framing", 64'(r.framing_ok), 64'd1);
                end
            end
        end
        check("uart_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic wait_frame_start(int bound);
        int s0;
        bit seen;
        s0   = frame_starts;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            #1;
            if (frame_starts != s0) seen = 1'b1;
        end
        check("frame_start_timeout", 64'(seen), 64'd1);
    endtask

    task automatic wave_check(string name, logic [7:0] b);
        logic [63:0] got, expw;
        int          k;
        logic        eb;
        exp_q.push_back(b);
        cpu_address = 16'hFF00;
        cpu_data    = {24'h0, b};
        cpu_wren    = 1'b1;
        #1;
        check({name, "_ram_wren"}, 64'(ram_wren), 64'd0);
        @(negedge clk);
        cpu_wren = 1'b0;
        got  = '0;
        expw = '0;
        for (int i = 0; i < NBits * Cpb + 4; i++) begin
            @(negedge clk);
            got[i] = tx;
            k = i / Cpb;
            if (k == 0)                  eb = 1'b0;
            else if (k <= 8)             eb = b[k-1];
            else if (ParEn && k == 9)    eb = ^b;
            else                         eb = 1'b1;
            expw[i] = eb;
        end
        check({name, "_waveform"}, got, expw);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic        wren;
        logic        exp_wren;
        logic        chk_q;
        logic [31:0] exp_q;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{16'h0010, 32'h12345678, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{16'h0010, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678};
        vecs[2]  = '{16'hFEFF, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{16'hFEFF, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
        vecs[4]  = '{16'hFF01, 32'h0,        1'b0, 1'b0, 1'b1, 32'h00000200};
        vecs[5]  = '{16'hFF00, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
        vecs[6]  = '{16'hFF05, 32'h00000055, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[7]  = '{16'hFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'h0};
        vecs[8]  = '{16'h0010, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678};
        vecs[9]  = '{16'hFF01, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'h00000200};
        vecs[10] = '{16'h00FF, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0};

        rst_n       = 1'b0;
        cpu_address = 16'h0;
        cpu_data    = 32'h0;
        cpu_wren    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx_high", 64'(tx), 64'd1);
        rst_n = 1'b1;
        rd_check("reset_status", 16'hFF01, 32'h00000200);

        // Address decode, pass-through and read-data steering.
        for (int i = 0; i < 11; i++) begin
            cpu_address = vecs[i].addr;
            cpu_data    = vecs[i].data;
            cpu_wren    = vecs[i].wren;
            #1;
            check($sformatf("vec%0d_ram_wren", i), 64'(ram_wren), 64'(vecs[i].exp_wren));
            check($sformatf("vec%0d_ram_address", i), 64'(ram_address), 64'(vecs[i].addr));
            check($sformatf("vec%0d_ram_data", i), 64'(ram_data), 64'(vecs[i].data));
            @(negedge clk);
            cpu_wren = 1'b0;
            if (vecs[i].chk_q) check($sformatf("vec%0d_cpu_q", i), 64'(cpu_q), 64'(vecs[i].exp_q));
        end

        // Overflow: first byte goes to the serializer, then nine bytes into an 8-deep FIFO.
        push_byte(8'h30);
        @(negedge clk);
        for (int i = 0; i < 8; i++) push_byte(8'h40 + 8'(i));
        wr(16'hFF00, 32'h00000048);
        rd_check("status_full_overflow", 16'hFF01, 32'h00000D08);
        wr(16'hFF01, 32'h0);
        rd_check("status_overflow_cleared", 16'hFF01, 32'h00000508);

        // Same-edge push and pop on a full FIFO: the next pop is 41 edges after a frame start.
        wait_frame_start(200);
        push_byte(8'h50);
        repeat (39) @(negedge clk);
        push_byte(8'h51);
        rd_check("status_push_on_pop", 16'hFF01, 32'h00000508);

        drain(1000);

        // Reset in the middle of the data bits with three bytes queued.
        wr(16'hFF00, 32'h0);
        @(negedge clk);
        wr(16'hFF00, 32'h62);
        wr(16'hFF00, 32'h63);
        wr(16'hFF00, 32'h64);
        repeat (8) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_mid_frame_tx", 64'(tx), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_check("status_after_abort", 16'hFF01, 32'h00000200);
        begin
            int n0;
            n0 = frame_starts;
            repeat (60) @(negedge clk);
            check("no_frame_after_reset", 64'(frame_starts), 64'(n0));
            check("no_rx_after_reset", 64'(rx_q.size()), 64'd0);
        end

        wave_check("a5", 8'hA5);
        drain(200);
        wave_check("x07", 8'h07);
        drain(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
